// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit big-endian bit length, and hands blocks downstream.
module sha256_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_first,
    output logic         block_last
);

    typedef enum logic [2:0] {
        FILL = 3'd0,
        PAD  = 3'd1,
        ZLEN = 3'd2,
        LEN  = 3'd3,
        EMIT = 3'd4
    } state_t;

    state_t             state_r;
    state_t             pend_r;
    logic [5:0]         ptr_r;
    logic [CNT_W-1:0]   msg_bytes_r;
    logic [63:0]        len_s;
    logic [8:0]         byte_hi_s;

    assign len_s     = {{(61-CNT_W){1'b0}}, msg_bytes_r, 3'b000};
    // MSB index of the byte slot selected by ptr; byte 0 sits at [511:504]
    assign byte_hi_s = 9'd511 - {ptr_r, 3'b000};

    // Padding FSM; block_out doubles as the assembly buffer so it is stable in EMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= FILL;
            pend_r      <= FILL;
            ptr_r       <= 6'd0;
            msg_bytes_r <= {CNT_W{1'b0}};
            block_out   <= 512'd0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
            block_first <= 1'b1;
            in_ready    <= 1'b1;
        end else begin
            case (state_r)
                FILL: begin
                    if (in_valid && !in_empty) begin
                        block_out[byte_hi_s -: 8] <= in_data;
                        ptr_r       <= ptr_r + 6'd1;
                        msg_bytes_r <= msg_bytes_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (ptr_r == 6'd63) begin
                            state_r     <= EMIT;
                            pend_r      <= in_last ? PAD : FILL;
                            block_valid <= 1'b1;
                            block_last  <= 1'b0;
                            in_ready    <= 1'b0;
                        end else if (in_last) begin
                            state_r  <= PAD;
                            in_ready <= 1'b0;
                        end
                    end else if (in_valid && in_last) begin
                        state_r  <= PAD;
                        in_ready <= 1'b0;
                    end
                end
                PAD: begin
                    for (int i = 0; i < 64; i++) begin
                        if (6'(i) == ptr_r) begin
                            block_out[511 - 8*i -: 8] <= 8'h80;
                        end else if (6'(i) > ptr_r) begin
                            block_out[511 - 8*i -: 8] <= 8'h00;
                        end
                    end
                    // No room for the length field: ship this block and build a length-only one
                    if (ptr_r <= 6'd55) begin
                        state_r <= LEN;
                    end else begin
                        state_r     <= EMIT;
                        pend_r      <= ZLEN;
                        block_valid <= 1'b1;
                        block_last  <= 1'b0;
                    end
                end
                ZLEN: begin
                    block_out   <= {448'd0, len_s};
                    state_r     <= EMIT;
                    block_valid <= 1'b1;
                    block_last  <= 1'b1;
                end
                LEN: begin
                    block_out[63:0] <= len_s;
                    state_r         <= EMIT;
                    block_valid     <= 1'b1;
                    block_last      <= 1'b1;
                end
                EMIT: begin
                    if (block_ready) begin
                        block_out   <= 512'd0;
                        ptr_r       <= 6'd0;
                        block_valid <= 1'b0;
                        if (block_last) begin
                            msg_bytes_r <= {CNT_W{1'b0}};
                            block_first <= 1'b1;
                            block_last  <= 1'b0;
                            state_r     <= FILL;
                            in_ready    <= 1'b1;
                        end else begin
                            block_first <= 1'b0;
                            state_r     <= pend_r;
                            in_ready    <= (pend_r == FILL);
                        end
                    end
                end
                default: begin
                    state_r     <= FILL;
                    block_valid <= 1'b0;
                    in_ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule
